// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Control FSM for the 16-bit multi-cycle datapath. Every instruction is
//   sequenced through FETCH / DECODE / EXEC / MEM / WB-style states. The FSM
//   drives the PC, IR, register-file and memory enables, and the datapath
//   mux selects.
//
//   Memory accesses wait on a ready handshake. A bounded wait counter turns a
//   stuck access into a timeout fault. Illegal opcodes also raise a fault.
//   Either fault parks the FSM in HALT until reset.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       synchronous, active-high reset
//   opcode_i      IR opcode field (valid from DECODE onward)
//   funct_i       IR funct field; consumed by the ALU decoder when alu_op = 111
//   alu_zero_i    ALU zero flag, used in BRANCH
//   mem_ready_i   completes the current fetch/load/store access
//   pc_write_o    PC load enable
//   ir_write_o    IR load enable
//   mem_read_o    memory read request
//   mem_write_o   memory write request
//   iord_o        address select: 0 = PC, 1 = ALU-out
//   reg_write_o   register-file write enable
//   reg_dst_o     destination select: 1 = rd, 0 = rt
//   mem_to_reg_o  write-back select: 1 = MDR, 0 = ALU-out
//   ext_sel_o     immediate extension: 0 = sign, 1 = zero
//   alu_src_a_o   ALU A select: 0 = PC, 1 = reg A
//   alu_src_b_o   ALU B select: 00 = reg B, 01 = const 1, 10 = extended imm
//   alu_op_o      000 add, 001 sub, 010 and, 011 or, 100 slt, 111 use funct
//   pc_src_o      PC source: 00 = ALU result, 01 = ALU-out, 10 = jump target
//   halted_o      high while the FSM sits in HALT
//   fault_o       00 none, 01 illegal opcode, 10 memory timeout (sticky)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int OPCODE_W = 4,
    parameter int FUNCT_W  = 3,
    parameter int MEM_TMO  = 15
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic                alu_zero_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                ir_write_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                iord_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                ext_sel_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [2:0]          alu_op_o,
    output logic [1:0]          pc_src_o,
    output logic                halted_o,
    output logic [1:0]          fault_o
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC    = 4'd2;
    localparam logic [3:0] S_WBALU   = 4'd3;
    localparam logic [3:0] S_MEMADDR = 4'd4;
    localparam logic [3:0] S_MEMACC  = 4'd5;
    localparam logic [3:0] S_WBMEM   = 4'd6;
    localparam logic [3:0] S_BRANCH  = 4'd7;
    localparam logic [3:0] S_JUMP    = 4'd8;
    localparam logic [3:0] S_HALT    = 4'd9;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(8);

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TMO     = 2'b10;

    // Count value at which one more idle cycle means the wait has reached
    // MEM_TMO; a ready seen in that same cycle still completes the access.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

    logic [3:0]          state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [7:0]          wait_q, wait_d;
    logic [1:0]          fault_q, fault_d;

    // The funct field is decoded by the ALU control, not by this FSM.
    logic funct_unused;
    assign funct_unused = ^funct_i;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic. The wait counter defaults to zero, so it is clear on
    // every entry to FETCH/MEMACC and only advances while an access stalls.
    // NOTE: every variable gets a default at the top of the block, which
    // keeps the combinational decode free of inferred latches.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = '0;
        fault_d = fault_q;
        case (state_q)
            S_FETCH, S_MEMACC: begin
                if (mem_ready_i) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (op_q == OP_LW) begin
                        state_d = S_WBMEM;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (wait_q == TMO_LAST) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TMO;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                op_d = opcode_i;
                if (opcode_i <= OP_ORI) begin
                    state_d = S_EXEC;
                end else if (opcode_i == OP_LW || opcode_i == OP_SW) begin
                    state_d = S_MEMADDR;
                end else if (opcode_i == OP_BEQ || opcode_i == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (opcode_i == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_HALT;
                    fault_d = FAULT_ILLEGAL;
                end
            end
            S_EXEC:    state_d = S_WBALU;
            S_MEMADDR: state_d = S_MEMACC;
            S_WBALU, S_WBMEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output decode. The outputs are Moore, taken from the state and the
    // latched opcode. Two exceptions look at inputs directly: the FETCH load
    // strobes follow mem_ready_i, and the BRANCH PC write follows alu_zero_i.
    // The outputs are forced idle while reset is asserted, so a pending
    // request drops in the reset cycle itself.
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        ext_sel_o    = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        pc_src_o     = 2'b00;
        halted_o     = 1'b0;
        fault_o      = FAULT_NONE;
        if (!reset_i) begin
            fault_o = fault_q;
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: alu_src_b_o = 2'b10;
                S_EXEC: begin
                    alu_src_a_o = 1'b1;
                    case (op_q)
                        OP_RTYPE: alu_op_o = 3'b111;
                        OP_ADDI:  alu_src_b_o = 2'b10;
                        OP_ANDI: begin
                            alu_src_b_o = 2'b10;
                            ext_sel_o   = 1'b1;
                            alu_op_o    = 3'b010;
                        end
                        OP_ORI: begin
                            alu_src_b_o = 2'b10;
                            ext_sel_o   = 1'b1;
                            alu_op_o    = 3'b011;
                        end
                        default: ;
                    endcase
                end
                S_WBALU: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = (op_q == OP_RTYPE);
                end
                S_MEMADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEMACC: begin
                    iord_o      = 1'b1;
                    mem_read_o  = (op_q == OP_LW);
                    mem_write_o = (op_q == OP_SW);
                end
                S_WBMEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 3'b001;
                    pc_src_o    = 2'b01;
                    pc_write_o  = (op_q == OP_BEQ) ? alu_zero_i : !alu_zero_i;
                end
                S_JUMP: begin
                    pc_src_o   = 2'b10;
                    pc_write_o = 1'b1;
                end
                S_HALT:  halted_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. Each step drives the inputs for one
//   cycle and pushes the expected control word onto a scoreboard queue. The
//   word is popped and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       alu_zero;
    logic       mem_ready;

    logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
    logic       reg_dst, mem_to_reg, ext_sel, alu_src_a, halted;
    logic [1:0] alu_src_b, pc_src, fault;
    logic [2:0] alu_op;

    multicycle_control #(.OPCODE_W(4), .FUNCT_W(3), .MEM_TMO(15)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .alu_zero_i   (alu_zero),
        .mem_ready_i  (mem_ready),
        .pc_write_o   (pc_write),
        .ir_write_o   (ir_write),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .iord_o       (iord),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .ext_sel_o    (ext_sel),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .pc_src_o     (pc_src),
        .halted_o     (halted),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    // Control word packed for whole-vector comparison.
    logic [19:0] obs;
    assign obs = {pc_write, ir_write, mem_read, mem_write, iord, reg_write,
                  reg_dst, mem_to_reg, ext_sel, alu_src_a, alu_src_b,
                  alu_op, pc_src, halted, fault};

    localparam logic [19:0] PCW     = 20'h80000;
    localparam logic [19:0] IRW     = 20'h40000;
    localparam logic [19:0] MRD     = 20'h20000;
    localparam logic [19:0] MWR     = 20'h10000;
    localparam logic [19:0] IORD    = 20'h08000;
    localparam logic [19:0] RW      = 20'h04000;
    localparam logic [19:0] RDST    = 20'h02000;
    localparam logic [19:0] M2R     = 20'h01000;
    localparam logic [19:0] EXT     = 20'h00800;
    localparam logic [19:0] ASA     = 20'h00400;
    localparam logic [19:0] ASB1    = 20'h00100;
    localparam logic [19:0] ASB2    = 20'h00200;
    localparam logic [19:0] AOP_SUB = 20'h00020;
    localparam logic [19:0] AOP_AND = 20'h00040;
    localparam logic [19:0] AOP_OR  = 20'h00060;
    localparam logic [19:0] AOP_FN  = 20'h000E0;
    localparam logic [19:0] PSRC1   = 20'h00008;
    localparam logic [19:0] PSRC2   = 20'h00010;
    localparam logic [19:0] HLT     = 20'h00004;
    localparam logic [19:0] FLT_ILL = 20'h00001;
    localparam logic [19:0] FLT_TMO = 20'h00002;

    // Expected control words per state, written out from the state table.
    localparam logic [19:0] IDLE    = 20'h00000;
    localparam logic [19:0] F_WAIT  = MRD | ASB1;
    localparam logic [19:0] F_RDY   = MRD | ASB1 | PCW | IRW;
    localparam logic [19:0] DEC     = ASB2;
    localparam logic [19:0] EX_R    = ASA | AOP_FN;
    localparam logic [19:0] EX_ADDI = ASA | ASB2;
    localparam logic [19:0] EX_ANDI = ASA | ASB2 | EXT | AOP_AND;
    localparam logic [19:0] EX_ORI  = ASA | ASB2 | EXT | AOP_OR;
    localparam logic [19:0] WB_R    = RW | RDST;
    localparam logic [19:0] WB_I    = RW;
    localparam logic [19:0] MADDR   = ASA | ASB2;
    localparam logic [19:0] ACC_LW  = IORD | MRD;
    localparam logic [19:0] ACC_SW  = IORD | MWR;
    localparam logic [19:0] WB_MEM  = RW | M2R;
    localparam logic [19:0] BR_NT   = ASA | AOP_SUB | PSRC1;
    localparam logic [19:0] BR_T    = ASA | AOP_SUB | PSRC1 | PCW;
    localparam logic [19:0] JMP     = PSRC2 | PCW;

    typedef struct {
        string       tag;
        logic [19:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // One clock of stimulus: inputs are already set, just after a rising edge.
    task automatic cyc(input string tag, input logic [19:0] exp);
        exp_t e;
        sb.push_back('{tag: tag, exp: exp});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed=%05h expected=%05h", e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 4'd0;
        funct     = 3'b101;
        alu_zero  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held for three cycles: everything idle.
        for (int i = 0; i < 3; i++) cyc("reset_idle", IDLE);

        // addi: the load strobes are high on the first FETCH cycle only.
        reset  = 1'b0;
        opcode = 4'd1;
        cyc("addi_fetch", F_RDY);
        cyc("addi_decode", DEC);
        cyc("addi_exec", EX_ADDI);
        cyc("addi_wb", WB_I);

        // ori: zero extension in EXEC. FETCH re-entry 4 cycles after addi.
        opcode = 4'd3;
        cyc("ori_fetch", F_RDY);
        cyc("ori_decode", DEC);
        cyc("ori_exec", EX_ORI);
        cyc("ori_wb", WB_I);

        // andi.
        opcode = 4'd2;
        cyc("andi_fetch", F_RDY);
        cyc("andi_decode", DEC);
        cyc("andi_exec", EX_ANDI);
        cyc("andi_wb", WB_I);

        // R-type: funct passthrough and rd destination.
        opcode = 4'd0;
        cyc("r_fetch", F_RDY);
        cyc("r_decode", DEC);
        cyc("r_exec", EX_R);
        cyc("r_wb", WB_R);

        // beq taken, then bne not taken, both with alu_zero = 1.
        opcode   = 4'd6;
        alu_zero = 1'b1;
        cyc("beq_fetch", F_RDY);
        cyc("beq_decode", DEC);
        cyc("beq_branch", BR_T);
        opcode = 4'd7;
        cyc("bne_fetch", F_RDY);
        cyc("bne_decode", DEC);
        cyc("bne_branch", BR_NT);
        alu_zero = 1'b0;

        // j.
        opcode = 4'd8;
        cyc("j_fetch", F_RDY);
        cyc("j_decode", DEC);
        cyc("j_jump", JMP);

        // lw: fetch stalls 2 cycles, then MEMACC stalls 3 cycles.
        opcode    = 4'd4;
        mem_ready = 1'b0;
        cyc("lw_fetch_wait", F_WAIT);
        cyc("lw_fetch_wait", F_WAIT);
        mem_ready = 1'b1;
        cyc("lw_fetch", F_RDY);
        cyc("lw_decode", DEC);
        cyc("lw_memaddr", MADDR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_memacc_wait", ACC_LW);
        mem_ready = 1'b1;
        cyc("lw_memacc_done", ACC_LW);
        cyc("lw_wbmem", WB_MEM);

        // sw with no ready: 15 stalled cycles, then HALT with a timeout fault.
        opcode = 4'd5;
        cyc("sw_fetch", F_RDY);
        cyc("sw_decode", DEC);
        cyc("sw_memaddr", MADDR);
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc("sw_memacc_wait", ACC_SW);
        cyc("sw_halt_tmo", HLT | FLT_TMO);
        mem_ready = 1'b1;
        alu_zero  = 1'b1;
        opcode    = 4'd8;
        cyc("sw_halt_sticky", HLT | FLT_TMO);
        cyc("sw_halt_sticky", HLT | FLT_TMO);

        // One reset cycle, then an illegal opcode halts straight from DECODE.
        reset = 1'b1;
        cyc("reset_from_halt", IDLE);
        reset  = 1'b0;
        opcode = 4'hC;
        cyc("ill_fetch", F_RDY);
        cyc("ill_decode", DEC);
        cyc("ill_halt", HLT | FLT_ILL);
        cyc("ill_halt_sticky", HLT | FLT_ILL);

        // Reset while a load request is pending drops it in the same cycle.
        reset = 1'b1;
        cyc("reset_from_ill", IDLE);
        reset  = 1'b0;
        opcode = 4'd4;
        cyc("mid_fetch", F_RDY);
        cyc("mid_decode", DEC);
        cyc("mid_memaddr", MADDR);
        mem_ready = 1'b0;
        cyc("mid_memacc", ACC_LW);
        cyc("mid_memacc", ACC_LW);
        reset = 1'b1;
        cyc("mid_reset_drop", IDLE);

        // Ready arriving on the 15th stalled FETCH cycle wins over the timeout.
        reset  = 1'b0;
        opcode = 4'd8;
        for (int i = 0; i < 14; i++) cyc("edge_fetch_wait", F_WAIT);
        mem_ready = 1'b1;
        cyc("edge_fetch_ready", F_RDY);
        cyc("edge_decode", DEC);
        cyc("edge_jump", JMP);
        cyc("edge_fetch_after", F_RDY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
